// File: rtl/cpu_ctrl_fsm_if.sv
// Control-unit bus bundle: instruction fetch, register file, ALU handshake and status.
// master = the control FSM, slave = the surrounding datapath/memory.
interface cpu_ctrl_fsm_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int CMD_WIDTH      = 16
);
  logic                      run;
  logic [ADDR_WIDTH-1:0]     imem_addr;
  logic                      imem_rd;
  logic [CMD_WIDTH-1:0]      imem_rdata;
  logic [REG_ADDR_WIDTH-1:0] rf_raddr_a;
  logic [REG_ADDR_WIDTH-1:0] rf_raddr_b;
  logic [DATA_WIDTH-1:0]     rf_rdata_a;
  logic                      rf_we;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr;
  logic [1:0]                rf_wsel;
  logic [DATA_WIDTH-1:0]     imm;
  logic                      alu_op;
  logic                      alu_start;
  logic                      alu_done;
  logic [ADDR_WIDTH-1:0]     pc;
  logic                      halted;
  logic                      illegal;

  modport master (
    input  run, imem_rdata, rf_rdata_a, alu_done,
    output imem_addr, imem_rd, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr,
           rf_wsel, imm, alu_op, alu_start, pc, halted, illegal
  );

  modport slave (
    output run, imem_rdata, rf_rdata_a, alu_done,
    input  imem_addr, imem_rd, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr,
           rf_wsel, imm, alu_op, alu_start, pc, halted, illegal
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit: FETCH -> DECODE -> EXEC -> (WAIT) -> WB per command,
// halting permanently on an undefined opcode.
module cpu_ctrl_fsm #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int CMD_WIDTH      = 16
) (
  input  logic          clk,
  input  logic          reset,
  cpu_ctrl_fsm_if.master bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [3:0] OP_MUL  = 4'd1;
  localparam logic [3:0] OP_XNOR = 4'd2;
  localparam logic [3:0] OP_MOV  = 4'd3;
  localparam logic [3:0] OP_JUMP = 4'd4;
  localparam logic [3:0] OP_LOAD = 4'd5;

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [CMD_WIDTH-1:0]  r_ir;
  logic                  r_jump_taken;
  logic                  r_illegal;

  logic [3:0]                w_op;
  logic [REG_ADDR_WIDTH-1:0] w_f1;
  logic [REG_ADDR_WIDTH-1:0] w_f2;
  logic [REG_ADDR_WIDTH-1:0] w_f3;
  logic                      w_is_alu;
  logic                      w_writes_rf;
  logic                      w_legal;

  assign w_op        = r_ir[CMD_WIDTH-1 -: 4];
  assign w_f1        = r_ir[11:8];
  assign w_f2        = r_ir[7:4];
  assign w_f3        = r_ir[3:0];
  assign w_is_alu    = (w_op == OP_MUL) || (w_op == OP_XNOR);
  assign w_writes_rf = w_is_alu || (w_op == OP_MOV) || (w_op == OP_LOAD);
  assign w_legal     = (w_op <= OP_LOAD);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_ir         <= '0;
      r_jump_taken <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:   if (bus.run) r_state <= S_FETCH;
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          r_ir    <= bus.imem_rdata;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (!w_legal) begin
            r_illegal <= 1'b1;
            r_state   <= S_HALT;
          end else begin
            // Branch condition is latched here; port A may change before WB.
            r_jump_taken <= (bus.rf_rdata_a != '0);
            r_state      <= w_is_alu ? S_WAIT : S_WB;
          end
        end
        S_WAIT:   if (bus.alu_done) r_state <= S_WB;
        S_WB: begin
          r_pc    <= ((w_op == OP_JUMP) && r_jump_taken) ? r_ir[ADDR_WIDTH-1:0] : r_pc + 1'b1;
          r_state <= S_FETCH;
        end
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.rf_waddr = w_f3;
    bus.rf_wsel  = 2'd0;
    if (w_op == OP_MOV) begin
      bus.rf_waddr = w_f2;
      bus.rf_wsel  = 2'd2;
    end else if (w_op == OP_LOAD) begin
      bus.rf_waddr = w_f1;
      bus.rf_wsel  = 2'd1;
    end
  end

  assign bus.imem_addr  = r_pc;
  assign bus.imem_rd    = (r_state == S_FETCH);
  assign bus.rf_raddr_a = w_f1;
  assign bus.rf_raddr_b = w_f2;
  assign bus.rf_we      = (r_state == S_WB) && w_writes_rf;
  assign bus.imm        = r_ir[DATA_WIDTH-1:0];
  assign bus.alu_op     = (w_op == OP_XNOR);
  assign bus.alu_start  = (r_state == S_EXEC) && w_is_alu;
  assign bus.pc         = r_pc;
  assign bus.halted     = (r_state == S_HALT);
  assign bus.illegal    = r_illegal;
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: models imem, register file and a variable-latency ALU,
// and matches every fetch, ALU start and register write against queued expectations.
module tb_cpu_ctrl_fsm;
  typedef struct { logic [7:0] addr; int t; } fetch_t;
  typedef struct { logic op; int t; int delay; } alu_t;
  typedef struct { logic [3:0] waddr; logic [1:0] wsel; logic [7:0] val; int t; } wr_t;

  localparam int NONE = 32'hDEAD;

  logic clk;
  logic reset;
  cpu_ctrl_fsm_if bus ();

  cpu_ctrl_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] imem [256];
  logic [7:0]  regs [16];
  logic [7:0]  alu_res;
  int          alu_done_at;
  int          t;
  int          n_checks;
  int          n_fail;

  fetch_t q_fetch[$];
  alu_t   q_alu[$];
  wr_t    q_wr[$];

  assign bus.rf_rdata_a = regs[bus.rf_raddr_a];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // One clock cycle of environment + scoreboard, evaluated at the falling edge.
  task automatic step();
    fetch_t f;
    alu_t   a;
    wr_t    w;
    int     ns;
    logic [7:0]  val;
    logic [15:0] prod;
    @(negedge clk);
    t++;
    bus.alu_done = (t == alu_done_at);
    ns = int'(bus.imem_rd) + int'(bus.rf_we) + int'(bus.alu_start);
    check("strobe_excl", int'(ns > 1), 0);
    if (bus.imem_rd) begin
      if (q_fetch.size() == 0) begin
        check("fetch_unexpected", int'(bus.imem_addr), NONE);
      end else begin
        f = q_fetch.pop_front();
        check("fetch_addr", int'(bus.imem_addr), int'(f.addr));
        check("fetch_time", t, f.t);
        $display("t=%0d fetch addr=%02h", t, bus.imem_addr);
      end
      bus.imem_rdata = imem[bus.imem_addr];
    end
    if (bus.alu_start) begin
      if (q_alu.size() == 0) begin
        check("alu_unexpected", int'(bus.alu_op), NONE);
      end else begin
        a = q_alu.pop_front();
        check("alu_op", int'(bus.alu_op), int'(a.op));
        check("alu_time", t, a.t);
        prod    = regs[bus.rf_raddr_a] * regs[bus.rf_raddr_b];
        alu_res = bus.alu_op ? ~(regs[bus.rf_raddr_a] ^ regs[bus.rf_raddr_b]) : prod[7:0];
        alu_done_at = t + a.delay;
        $display("t=%0d alu_start op=%0d delay=%0d", t, bus.alu_op, a.delay);
      end
    end
    if (bus.rf_we) begin
      case (bus.rf_wsel)
        2'd0:    val = alu_res;
        2'd1:    val = bus.imm;
        2'd2:    val = bus.rf_rdata_a;
        default: val = 8'hxx;
      endcase
      if (q_wr.size() == 0) begin
        check("wr_unexpected", int'(bus.rf_waddr), NONE);
      end else begin
        w = q_wr.pop_front();
        check("wr_addr", int'(bus.rf_waddr), int'(w.waddr));
        check("wr_sel", int'(bus.rf_wsel), int'(w.wsel));
        check("wr_val", int'(val), int'(w.val));
        check("wr_time", t, w.t);
        $display("t=%0d rf_write R%0d <= %02h (wsel=%0d)", t, bus.rf_waddr, val, bus.rf_wsel);
      end
      regs[bus.rf_waddr] = val;
    end
  endtask

  // Pulse run for one cycle (t=0 is the first FETCH), optionally pulling reset low at rst_at.
  task automatic run_cycles(input int n, input int rst_at, input int pc_at, input int pc_exp);
    alu_done_at = -100;
    bus.run = 1'b1;
    t = -1;
    for (int i = 0; i < n; i++) begin
      step();
      bus.run = 1'b0;
      reset = (t == rst_at) ? 1'b0 : 1'b1;
      if (t == pc_at) check("pc_mid", int'(bus.pc), pc_exp);
    end
    reset = 1'b1;
    check("fetch_left", q_fetch.size(), 0);
    check("alu_left", q_alu.size(), 0);
    check("wr_left", q_wr.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    check("rst_halted", int'(bus.halted), 0);
    check("rst_illegal", int'(bus.illegal), 0);
    check("rst_pc", int'(bus.pc), 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    t = -1000;
    alu_done_at = -100;
    alu_res = 8'h00;
    bus.run = 1'b0;
    bus.alu_done = 1'b0;
    bus.imem_rdata = 16'h0000;
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check("init_halted", int'(bus.halted), 0);
    check("init_illegal", int'(bus.illegal), 0);
    check("init_pc", int'(bus.pc), 0);
    check("init_imem_rd", int'(bus.imem_rd), 0);
    check("init_rf_we", int'(bus.rf_we), 0);
    check("init_alu_start", int'(bus.alu_start), 0);
    repeat (3) step();

    // Program A: LOAD, LOAD, MUL (N=3), XNOR (N=1), MOV, JUMP not taken, illegal at 6.
    imem[0] = 16'h510A;
    imem[1] = 16'h5203;
    imem[2] = 16'h1124;
    imem[3] = 16'h2125;
    imem[4] = 16'h3460;
    imem[5] = 16'h4009;
    imem[6] = 16'hA123;
    q_fetch.push_back('{8'h00, 0});
    q_fetch.push_back('{8'h01, 4});
    q_fetch.push_back('{8'h02, 8});
    q_fetch.push_back('{8'h03, 15});
    q_fetch.push_back('{8'h04, 20});
    q_fetch.push_back('{8'h05, 24});
    q_fetch.push_back('{8'h06, 28});
    q_alu.push_back('{1'b0, 10, 3});
    q_alu.push_back('{1'b1, 17, 1});
    q_wr.push_back('{4'd1, 2'd1, 8'd10, 3});
    q_wr.push_back('{4'd2, 2'd1, 8'd3, 7});
    q_wr.push_back('{4'd4, 2'd0, 8'd30, 14});
    q_wr.push_back('{4'd5, 2'd0, 8'hF6, 19});
    q_wr.push_back('{4'd6, 2'd2, 8'd30, 23});
    run_cycles(41, -1, 25, 5);
    check("halt_halted", int'(bus.halted), 1);
    check("halt_illegal", int'(bus.illegal), 1);
    check("halt_pc", int'(bus.pc), 6);
    do_reset();

    // Program B: taken JUMP to 0xFF, NOP there wraps pc to 0x00, reset mid-command.
    imem[0]   = 16'h5005;
    imem[1]   = 16'h40FF;
    imem[255] = 16'h0000;
    q_fetch.push_back('{8'h00, 0});
    q_fetch.push_back('{8'h01, 4});
    q_fetch.push_back('{8'hFF, 8});
    q_fetch.push_back('{8'h00, 12});
    q_wr.push_back('{4'd0, 2'd1, 8'd5, 3});
    run_cycles(18, 13, 8, 8'hFF);
    check("wrap_rst_pc", int'(bus.pc), 0);

    // Program C: reset while in WAIT; alu_done arrives in IDLE and must be ignored.
    imem[0] = 16'h1124;
    q_fetch.push_back('{8'h00, 0});
    q_alu.push_back('{1'b0, 2, 2});
    run_cycles(10, 3, 9, 0);
    check("wait_rst_halted", int'(bus.halted), 0);
    check("wait_rst_rf_we", int'(bus.rf_we), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
